// File: rtl/sensor_poll_ctrl.sv
// Periodic Avalon-MM poller for the sensor PIO: debounces each sample, latches edges,
// raises a maskable level IRQ and exposes state through a small Avalon-MM slave.
module sensor_poll_ctrl #(
  parameter int WIDTH    = 3,
  parameter int PERIOD   = 50000,
  parameter int DEBOUNCE = 4,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 2;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [TW-1:0] RELOAD   = TW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, EVAL} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [LW-1:0]    wait_cnt;
  logic             poll_pend, force_pend, enable;
  logic [WIDTH-1:0] sample_p0, cand, stable, edge_flags, mask;
  logic [CW-1:0]    cnt;

  logic             timer_fire, take, force_wr;
  logic [WIDTH-1:0] edge_clr, new_edges, cand_nxt, stable_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  assign m_address   = 2'b00;
  assign unused_bits = ^{m_readdata[31:WIDTH], s_writedata[31:WIDTH]};

  assign timer_fire = enable && (timer == '0);
  assign take       = (state == IDLE) && (poll_pend || force_pend);
  assign force_wr   = s_write && (s_address == 2'd3) && s_writedata[1];
  assign edge_clr   = (s_write && (s_address == 2'd1)) ? s_writedata[WIDTH-1:0] : '0;

  // Debounce decision, evaluated only in EVAL on the captured sample
  always_comb begin
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    new_edges  = '0;
    if (state == EVAL) begin
      if (sample_p0 == cand) begin
        cnt_nxt = sat_inc(cnt);
      end else begin
        cand_nxt = sample_p0;
        cnt_nxt  = CW'(1);
      end
      if ((cnt_nxt == CNT_MAX) && (cand_nxt != stable)) begin
        stable_nxt = cand_nxt;
        new_edges  = cand_nxt ^ stable;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      2'd0: rd_mux[WIDTH-1:0] = stable;
      2'd1: rd_mux[WIDTH-1:0] = edge_flags;
      2'd2: rd_mux[WIDTH-1:0] = mask;
      default: rd_mux[0] = enable;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= RELOAD;
      poll_pend  <= 1'b0;
      force_pend <= 1'b0;
      state      <= IDLE;
      m_read     <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      timer      <= (!enable || timer == '0) ? RELOAD : timer - 1'b1;
      poll_pend  <= enable && (timer_fire || (poll_pend && !take));
      // A force written in the READ cycle must survive the clear
      force_pend <= force_wr || (force_pend && state != READ);
      case (state)
        IDLE: if (take) begin
          state  <= READ;
          m_read <= 1'b1;
        end
        READ: begin
          state    <= WAIT;
          m_read   <= 1'b0;
          wait_cnt <= '0;
        end
        WAIT: if (wait_cnt == LAT_LAST) state <= EVAL;
              else wait_cnt <= wait_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: capture PIO data in the last WAIT cycle, when readdata is valid
  always_ff @(posedge clk) begin
    if (state == WAIT && wait_cnt == LAT_LAST) sample_p0 <= m_readdata[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand       <= '0;
      cnt        <= '0;
      stable     <= '0;
      edge_flags <= '0;
      mask       <= '0;
      enable     <= 1'b0;
      irq        <= 1'b0;
      s_readdata <= '0;
    end else begin
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      stable     <= stable_nxt;
      edge_flags <= (edge_flags & ~edge_clr) | new_edges;
      irq        <= |(edge_flags & mask);
      if (s_write && s_address == 2'd2) mask <= s_writedata[WIDTH-1:0];
      if (s_write && s_address == 2'd3) enable <= s_writedata[0];
      if (s_read) s_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Randomized bench for sensor_poll_ctrl: a PIO responder feeds samples to a
// sample-history debounce model; slave readback, irq and m_read timing are compared.
module tb_sensor_poll_ctrl;
  localparam int W = 3, PER = 8, DB = 3, LAT = 1;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata = '0;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        irq;

  sensor_poll_ctrl #(.WIDTH(W), .PERIOD(PER), .DEBOUNCE(DB), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .m_address(m_address), .m_read(m_read),
    .m_readdata(m_readdata), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, rd_pulses = 0, last_rd_cyc = 0, eval_cyc = -10;
  bit rd_prev = 1'b0;
  logic [W-1:0] pio = '0, m_stable, m_edge, m_mask, last_new;
  logic [W-1:0] hist[$];
  logic [31:0] rsp_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_stable = '0; m_edge = '0; m_mask = '0; last_new = '0; eval_cyc = -10;
  endfunction

  // Stable follows a value once the last DB samples all equal it
  function automatic void model_sample(input logic [W-1:0] s);
    bit all_same = 1'b1;
    hist.push_back(s);
    if (hist.size() > DB) hist.delete(0);
    last_new = '0;
    eval_cyc = cyc + 1;
    if (hist.size() == DB) begin
      foreach (hist[i]) if (hist[i] != s) all_same = 1'b0;
      if (all_same && s != m_stable) begin
        last_new = s ^ m_stable;
        m_edge   = m_edge | last_new;
        m_stable = s;
      end
    end
  endfunction

  // PIO slave: data is valid only RD_LAT cycles after m_read, garbage otherwise
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      rsp_d = $urandom;
      if (rd_prev) begin
        rsp_d[W-1:0] = pio;
        model_sample(pio);
      end
      m_readdata = rsp_d;
      if (m_read === 1'b1) begin
        chk("mread_width", 32'(rd_prev), 32'd0);
        chk("m_address", 32'(m_address), 32'd0);
        rd_pulses++;
        last_rd_cyc = cyc;
      end
      rd_prev = (m_read === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic sw(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    if (a == 2'd1) m_edge = (m_edge & ~d[W-1:0]) | ((cyc == eval_cyc) ? last_new : '0);
    if (a == 2'd2) m_mask = d[W-1:0];
    step();
    s_write = 1'b0;
  endtask

  task automatic sr(input logic [1:0] a, output logic [31:0] v);
    s_address = a; s_read = 1'b1;
    step();
    s_read = 1'b0;
    v = s_readdata;
  endtask

  task automatic chk_regs();
    logic [31:0] v;
    sr(2'd0, v); chk("stable", v, {29'd0, m_stable});
    sr(2'd1, v); chk("edge", v, {29'd0, m_edge});
  endtask

  task automatic chk_irq();
    step(); step();
    chk("irq", 32'(irq), 32'(|(m_edge & m_mask)));
  endtask

  task automatic wait_poll(input int budget, output int pc);
    int n;
    n = rd_pulses;
    pc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rd_pulses != n) begin
        pc = last_rd_cyc;
        return;
      end
    end
    chk("poll_timeout", rd_pulses - n, 1);
  endtask

  task automatic count_pulses(input int ncyc, input int exp, input string tag);
    int n0;
    n0 = rd_pulses;
    repeat (ncyc) step();
    chk(tag, rd_pulses - n0, exp);
  endtask

  task automatic force_poll();
    int p;
    sw(2'd3, 32'd2);
    wait_poll(20, p);
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int p1, p2, p3;
    logic [W-1:0] gseq[6] = '{3'd5, 3'd5, 3'd0, 3'd5, 3'd5, 3'd5};
    bit irq_before;

    model_reset();
    do_reset();
    chk("rst_mread", 32'(m_read), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_sreaddata", s_readdata, 0);
    for (int a = 0; a < 4; a++) begin
      sr(2'(a), v);
      chk("rst_reg", v, 0);
    end
    count_pulses(20, 0, "idle_no_poll");

    // Periodic polling: three polls of 101
    pio = 3'b101;
    sw(2'd3, 32'd1);
    wait_poll(30, p1); repeat (3) step(); chk_regs();
    wait_poll(30, p2); chk("period", p2 - p1, PER); repeat (3) step(); chk_regs();
    wait_poll(30, p3); chk("period", p3 - p2, PER); repeat (3) step(); chk_regs();
    sw(2'd3, 32'd0);
    repeat (10) step();
    count_pulses(30, 0, "disabled_no_poll");

    // Mask, irq and W1C
    sw(2'd2, 32'd4);
    chk_irq();
    irq_before = |(m_edge & m_mask);
    sw(2'd1, 32'd4);
    chk("irq_lag", 32'(irq), 32'(irq_before));
    step();
    chk("irq_after_w1c", 32'(irq), 32'(|(m_edge & m_mask)));
    chk_regs();

    // W1C on bit2 in the same cycle a new bit2 edge is recorded
    pio = 3'b001;
    for (int k = 0; k < 3; k++) begin
      sw(2'd3, 32'd2);
      wait_poll(20, p1);
      if (k == 2) begin
        step(); step();
        sw(2'd1, 32'd4);
      end
      repeat (3) step();
    end
    chk_regs();
    chk_irq();

    // Simultaneous read and write of MASK returns the old value
    s_address = 2'd2; s_writedata = 32'd3; s_read = 1'b1; s_write = 1'b1;
    step();
    s_read = 1'b0; s_write = 1'b0;
    chk("rw_same_reg", s_readdata, {29'd0, m_mask});
    m_mask = 3'd3;
    sr(2'd2, v); chk("mask", v, {29'd0, m_mask});

    // Glitch sequence restarts the debounce count
    do_reset();
    foreach (gseq[i]) begin
      pio = gseq[i];
      force_poll();
      chk_regs();
    end
    sw(2'd3, 32'd2);
    count_pulses(20, 1, "force_one");

    // Force written while a poll is in WAIT
    pio = 3'b010;
    sw(2'd3, 32'd2);
    wait_poll(20, p1);
    step();
    sw(2'd3, 32'd2);
    count_pulses(20, 1, "force_in_wait");
    chk_regs();

    // Randomized polls, mask writes and edge clears
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        if ($urandom_range(0, 3) == 0) pio = 3'($urandom);
        force_poll();
      end else if (r < 8) begin
        sw(2'd2, $urandom);
      end else begin
        sw(2'd1, $urandom);
      end
      chk_irq();
      chk_regs();
    end

    // Reset asserted while a poll is in WAIT
    sw(2'd2, 32'd7);
    pio = 3'b111;
    sw(2'd3, 32'd3);
    wait_poll(20, p1);
    step();
    reset = 1'b1;
    step();
    chk("rstwait_mread", 32'(m_read), 0);
    chk("rstwait_irq", 32'(irq), 0);
    chk("rstwait_sreaddata", s_readdata, 0);
    reset = 1'b0;
    model_reset();
    repeat (3) step();
    chk_regs();
    sr(2'd2, v); chk("rstwait_mask", v, 0);
    sr(2'd3, v); chk("rstwait_ctrl", v, 0);
    count_pulses(30, 0, "rstwait_no_poll");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
